cc_demux_12: RTL and testbench
==============================

# cc_demux_12

Registered 1-to-2 demultiplexer that routes a valid/ready input word stream to one of two output channels. It is the distribution-side counterpart of the 2:1 bus multiplexer. Each channel has its own one-word holding register and handshake, so a stalled consumer blocks only the words addressed to it. Channel selection comes from a select input or from an internal round-robin pointer. Per-channel delivered-word counters are provided for debug and for the verification scoreboard.

## Interface
- NUMBER_DATAWIDTH, 8, width of data words
- NUMBER_COUNTWIDTH, 8, width of each delivered-word counter
- CC_DEMUX_12_CLOCK_50  in  1  single clock, rising edge
- CC_DEMUX_12_RESET_InLow  in  1  reset, asynchronous, active-low
- CC_DEMUX_12_autoSelect_In  in  1  1 = round-robin selection, 0 = use select input
- CC_DEMUX_12_select_InBUS  in  1  0 = channel 1, 1 = channel 2 (used when autoSelect=0)
- CC_DEMUX_12_data_InBUS  in  NUMBER_DATAWIDTH  input word
- CC_DEMUX_12_valid_In  in  1  input word valid
- CC_DEMUX_12_ready_Out  out  1  block can accept the input word this cycle
- CC_DEMUX_12_data1_OutBUS / CC_DEMUX_12_data2_OutBUS  out  NUMBER_DATAWIDTH  channel word
- CC_DEMUX_12_valid1_Out / CC_DEMUX_12_valid2_Out  out  1  channel word valid
- CC_DEMUX_12_ready1_In / CC_DEMUX_12_ready2_In  in  1  channel consumer ready
- CC_DEMUX_12_count1_OutBUS / CC_DEMUX_12_count2_OutBUS  out  NUMBER_COUNTWIDTH  words delivered per channel

## Operation
- **Target channel:** tgt = autoSelect ? rr_ptr : select. Evaluated combinationally every cycle.
- **Slot state:** each channel slot has two states, EMPTY and FULL; valid_k = FULL.
- **ready_Out:**
  - ready_Out = (slot[tgt] EMPTY) OR (slot[tgt] FULL AND ready_tgt).
  - This is a combinational path from ready_k.
  - ready_Out is forced to 0 while reset is asserted.
- **Accept:** valid_In AND ready_Out. On accept, data_In loads into slot[tgt] and that slot becomes FULL.
- **Drain:** on channel k, drain is valid_k AND ready_k. The slot becomes EMPTY unless it is reloaded on the same edge; in that case it stays FULL with the new word.
- **Round-robin pointer:**
  - rr_ptr toggles only on an accept while autoSelect=1.
  - While autoSelect=0 it holds its value.
  - Switching modes does not reset rr_ptr.
- **Counters:** count_k increments by 1 on each drain of channel k and wraps from 2^NUMBER_COUNTWIDTH-1 to 0.
- **Data stability:** data_k is stable while valid_k=1 and ready_k=0. data_k holds its last value while EMPTY.
- **Head-of-line blocking:** a word targeting a stalled channel blocks the input even if the other channel is free. The block does not reorder words.

## Timing
- **Reset (asynchronous, immediate):**
  - Both slots EMPTY; valid1=valid2=0.
  - data1=data2=0; count1=count2=0; rr_ptr=0 (channel 1); ready_Out=0.
- **Reset release:** ready_Out=1 in the first cycle after reset is released.
- **Latency:** a word accepted at edge N appears on data_k with valid_k=1 immediately after edge N, i.e. 1 cycle of latency.
- **Throughput:** 1 word/cycle sustained to either channel while its ready_k=1 (simultaneous drain and reload).
- **Simultaneous events:**
  - Drain on channel 1 and accept to channel 2 in the same cycle are independent; both take effect.
  - Drain and accept on the same channel in the same cycle reload the slot; count_k still increments.
- **Reset mid-operation:** words held in the slots are discarded; no drain is counted.

## Structure
- A shared Verilog include file holds the channel index constants (CH1=1'b0, CH2=1'b1) and the slot state encoding (EMPTY=1'b0, FULL=1'b1).
- Sub-module cc_demux_12_slot contains one holding register, its FULL flag, the drain logic and the wrap counter. The top instantiates it twice.
- The top level contains target selection, rr_ptr and ready_Out.

## Test plan
- **Reset:** assert reset with both slots FULL, valid1=valid2=1, count1=3 -> valid1=valid2=0, count1=0 and ready_Out=0 without waiting for a clock edge; ready_Out=1 after release.
- **Manual routing:** autoSelect=0, ready1=ready2=1; send 0x11 (select=0) then 0x22 (select=1) -> data1=0x11 one cycle after its accept, data2=0x22 one cycle after its accept; count1=count2=1.
- **Round-robin:** autoSelect=1, ready1=ready2=1; stream 0xA0..0xA5 back-to-back -> channel 1 gets A0,A2,A4 and channel 2 gets A1,A3,A5; ready_Out stays 1; each count ends at 3.
- **Stall:** autoSelect=0, ready1=0; send 0x55 to channel 1 then 0x66 to channel 1 -> data1 holds 0x55 and ready_Out=0 while 0x66 is presented.
  - Raise ready1 -> same-cycle drain and reload; data1=0x66 next cycle.
- **Independence:** ready1=0 with slot 1 FULL; send 0x77 to channel 2 -> accepted; valid2=1 and data2=0x77 while valid1 stays 1.
- **Wrap:** NUMBER_COUNTWIDTH=4; deliver 17 words to channel 2 -> count2=1; count1 stays 0.

Source files
------------

// File: rtl/cc_demux_12_pkg.sv
// Shared definitions for the 1-to-2 registered demultiplexer: channel indices,
// slot state encoding and the target-channel selection helper.
package cc_demux_12_pkg;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_t;

    // Round-robin pointer wins over the select input whenever autoSelect is set.
    function automatic logic pickTarget(
        input logic autoSelect,
        input logic rrPtr,
        input logic selectBus
    );
        return autoSelect ? rrPtr : selectBus;
    endfunction

endpackage

// File: rtl/cc_demux_12_slot.sv
// One output channel of the demux: a one-word holding register with its
// FULL flag, the valid/ready drain logic and a wrapping delivered-word counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no word held; valid low, data keeps the last delivered word
// FULL  | word held and presented; leaves only on a drain without reload
module cc_demux_12_slot
    import cc_demux_12_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH  = 8,
    parameter int NUMBER_COUNTWIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUMBER_DATAWIDTH-1:0]  loadData,
    input  logic                         consumerReady,
    output logic                         slotValid,
    output logic                         slotFull,
    output logic [NUMBER_DATAWIDTH-1:0]  slotData,
    output logic [NUMBER_COUNTWIDTH-1:0] slotCount
);

    slotState_t                   state;
    slotState_t                   nextState;
    logic                         drain;
    logic [NUMBER_DATAWIDTH-1:0]  dataReg;
    logic [NUMBER_COUNTWIDTH-1:0] countReg;

    assign drain = (state == FULL) && consumerReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // A reload on the drain edge keeps the slot FULL with the new word.
    always_comb begin
        nextState = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    nextState = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    nextState = FULL;
                end else if (drain) begin
                    nextState = EMPTY;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataReg <= '0;
        end else if (load) begin
            dataReg <= loadData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (drain) begin
            countReg <= countReg + NUMBER_COUNTWIDTH'(1);
        end
    end

    assign slotValid = (state == FULL);
    assign slotFull  = (state == FULL);
    assign slotData  = dataReg;
    assign slotCount = countReg;

endmodule

// File: rtl/cc_demux_12.sv
// Registered 1-to-2 demultiplexer: routes a valid/ready word stream to one of
// two independently handshaked channel slots, by select input or round-robin.
module cc_demux_12
    import cc_demux_12_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH  = 8,
    parameter int NUMBER_COUNTWIDTH = 8
) (
    input  logic                         CC_DEMUX_12_CLOCK_50,
    input  logic                         CC_DEMUX_12_RESET_InLow,
    input  logic                         CC_DEMUX_12_autoSelect_In,
    input  logic                         CC_DEMUX_12_select_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0]  CC_DEMUX_12_data_InBUS,
    input  logic                         CC_DEMUX_12_valid_In,
    output logic                         CC_DEMUX_12_ready_Out,
    output logic [NUMBER_DATAWIDTH-1:0]  CC_DEMUX_12_data1_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0]  CC_DEMUX_12_data2_OutBUS,
    output logic                         CC_DEMUX_12_valid1_Out,
    output logic                         CC_DEMUX_12_valid2_Out,
    input  logic                         CC_DEMUX_12_ready1_In,
    input  logic                         CC_DEMUX_12_ready2_In,
    output logic [NUMBER_COUNTWIDTH-1:0] CC_DEMUX_12_count1_OutBUS,
    output logic [NUMBER_COUNTWIDTH-1:0] CC_DEMUX_12_count2_OutBUS
);

    logic clk;
    logic rst_n;
    logic target;
    logic targetFull;
    logic targetReady;
    logic accept;
    logic load1;
    logic load2;
    logic full1;
    logic full2;
    logic rrPtr;

    assign clk   = CC_DEMUX_12_CLOCK_50;
    assign rst_n = CC_DEMUX_12_RESET_InLow;

    assign target = pickTarget(CC_DEMUX_12_autoSelect_In, rrPtr, CC_DEMUX_12_select_InBUS);

    always_comb begin
        targetFull  = full1;
        targetReady = CC_DEMUX_12_ready1_In;
        if (target == CH2) begin
            targetFull  = full2;
            targetReady = CC_DEMUX_12_ready2_In;
        end
    end

    // Only the addressed slot gates the input, so a stalled target blocks the
    // stream even when the other slot is free; ordering is never changed.
    assign CC_DEMUX_12_ready_Out = rst_n && (!targetFull || targetReady);

    assign accept = CC_DEMUX_12_valid_In && CC_DEMUX_12_ready_Out;
    assign load1  = accept && (target == CH1);
    assign load2  = accept && (target == CH2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= CH1;
        end else if (accept && CC_DEMUX_12_autoSelect_In) begin
            rrPtr <= ~rrPtr;
        end
    end

    cc_demux_12_slot #(
        .NUMBER_DATAWIDTH  (NUMBER_DATAWIDTH),
        .NUMBER_COUNTWIDTH (NUMBER_COUNTWIDTH)
    ) slot1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load1),
        .loadData      (CC_DEMUX_12_data_InBUS),
        .consumerReady (CC_DEMUX_12_ready1_In),
        .slotValid     (CC_DEMUX_12_valid1_Out),
        .slotFull      (full1),
        .slotData      (CC_DEMUX_12_data1_OutBUS),
        .slotCount     (CC_DEMUX_12_count1_OutBUS)
    );

    cc_demux_12_slot #(
        .NUMBER_DATAWIDTH  (NUMBER_DATAWIDTH),
        .NUMBER_COUNTWIDTH (NUMBER_COUNTWIDTH)
    ) slot2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load2),
        .loadData      (CC_DEMUX_12_data_InBUS),
        .consumerReady (CC_DEMUX_12_ready2_In),
        .slotValid     (CC_DEMUX_12_valid2_Out),
        .slotFull      (full2),
        .slotData      (CC_DEMUX_12_data2_OutBUS),
        .slotCount     (CC_DEMUX_12_count2_OutBUS)
    );

endmodule

// File: tb/tb_cc_demux_12.sv
// Scoreboard bench for cc_demux_12: stimulus pushes expected words per channel,
// a monitor pops and compares them on every drain handshake.
module tb_cc_demux_12;

    logic       clk;
    logic       rst_n;
    logic       autoSel;
    logic       sel;
    logic [7:0] dIn;
    logic       vIn;
    logic       rdyOut;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       v1;
    logic       v2;
    logic       r1;
    logic       r2;
    logic [3:0] c1;
    logic [3:0] c2;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [3:0] m1;
    logic [3:0] m2;
    logic       rrModel;
    int         checks;
    int         failures;
    int         w;

    cc_demux_12 #(
        .NUMBER_DATAWIDTH  (8),
        .NUMBER_COUNTWIDTH (4)
    ) dut (
        .CC_DEMUX_12_CLOCK_50      (clk),
        .CC_DEMUX_12_RESET_InLow   (rst_n),
        .CC_DEMUX_12_autoSelect_In (autoSel),
        .CC_DEMUX_12_select_InBUS  (sel),
        .CC_DEMUX_12_data_InBUS    (dIn),
        .CC_DEMUX_12_valid_In      (vIn),
        .CC_DEMUX_12_ready_Out     (rdyOut),
        .CC_DEMUX_12_data1_OutBUS  (d1),
        .CC_DEMUX_12_data2_OutBUS  (d2),
        .CC_DEMUX_12_valid1_Out    (v1),
        .CC_DEMUX_12_valid2_Out    (v2),
        .CC_DEMUX_12_ready1_In     (r1),
        .CC_DEMUX_12_ready2_In     (r2),
        .CC_DEMUX_12_count1_OutBUS (c1),
        .CC_DEMUX_12_count2_OutBUS (c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flagTimeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
    endtask

    // Drain handshakes are sampled mid-cycle; the word leaves on the next edge.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("count1", 32'(c1), 32'(m1));
                chk("count2", 32'(c2), 32'(m2));
                if (v1 && r1) begin
                    if (q1.size() == 0) begin
                        chk("ch1_unexpected", 32'(d1), 32'hFFFF_FFFF);
                    end else begin
                        e = q1.pop_front();
                        chk("ch1_data", 32'(d1), 32'(e));
                        m1 = m1 + 4'd1;
                    end
                end
                if (v2 && r2) begin
                    if (q2.size() == 0) begin
                        chk("ch2_unexpected", 32'(d2), 32'hFFFF_FFFF);
                    end else begin
                        e = q2.pop_front();
                        chk("ch2_data", 32'(d2), 32'(e));
                        m2 = m2 + 4'd1;
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic s, output int waits);
        logic ch;
        bit   got;
        got   = 0;
        waits = 0;
        ch    = 1'b0;
        dIn   = d;
        sel   = s;
        vIn   = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rdyOut) begin
                got = 1;
                ch  = autoSel ? rrModel : s;
                if (autoSel) rrModel = ~rrModel;
                if (ch) q2.push_back(d);
                else    q1.push_back(d);
            end else begin
                waits++;
            end
        end
        if (!got) begin
            flagTimeout("send_accept");
            @(posedge clk);
            #1;
            vIn = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vIn = 1'b0;
        if (ch) begin
            chk("latency_valid2", 32'(v2), 32'd1);
            chk("latency_data2", 32'(d2), 32'(d));
        end else begin
            chk("latency_valid1", 32'(v1), 32'd1);
            chk("latency_data1", 32'(d1), 32'(d));
        end
    endtask

    task automatic waitEmpty();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q2.size() == 0 && !v1 && !v2) done = 1;
        end
        if (!done) flagTimeout("drain_wait");
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m1       = 4'd0;
        m2       = 4'd0;
        rrModel  = 1'b0;
        rst_n    = 1'b0;
        autoSel  = 1'b0;
        sel      = 1'b0;
        dIn      = 8'h00;
        vIn      = 1'b0;
        r1       = 1'b1;
        r2       = 1'b1;
        fork
            monitor();
        join_none

        #2;
        chk("reset_ready", 32'(rdyOut), 32'd0);
        chk("reset_valid1", 32'(v1), 32'd0);
        chk("reset_valid2", 32'(v2), 32'd0);
        chk("reset_data1", 32'(d1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(rdyOut), 32'd1);
        @(posedge clk);
        #1;

        // Manual routing
        send(8'h11, 1'b0, w);
        send(8'h22, 1'b1, w);
        waitEmpty();
        chk("manual_count1", 32'(c1), 32'd1);
        chk("manual_count2", 32'(c2), 32'd1);

        // Round-robin stream, no stalls expected
        autoSel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'hA0 + 8'(i), 1'b0, w);
            chk("rr_no_wait", 32'(w), 32'd0);
        end
        waitEmpty();
        chk("rr_count1", 32'(c1), 32'd4);
        chk("rr_count2", 32'(c2), 32'd4);

        // Stall and same-cycle drain/reload
        autoSel = 1'b0;
        r1      = 1'b0;
        send(8'h55, 1'b0, w);
        dIn = 8'h66;
        sel = 1'b0;
        vIn = 1'b1;
        @(negedge clk);
        chk("stall_ready", 32'(rdyOut), 32'd0);
        chk("stall_data1", 32'(d1), 32'h55);
        chk("stall_valid1", 32'(v1), 32'd1);
        @(posedge clk);
        #1;
        r1 = 1'b1;
        send(8'h66, 1'b0, w);
        chk("reload_no_wait", 32'(w), 32'd0);
        waitEmpty();

        // Independence: stalled channel 1 does not block channel 2
        r1 = 1'b0;
        r2 = 1'b0;
        send(8'h33, 1'b0, w);
        send(8'h77, 1'b1, w);
        chk("indep_no_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("indep_valid1", 32'(v1), 32'd1);
        chk("indep_valid2", 32'(v2), 32'd1);
        chk("indep_data2", 32'(d2), 32'h77);
        @(posedge clk);
        #1;
        r1 = 1'b1;
        r2 = 1'b1;
        waitEmpty();
        chk("indep_count1", 32'(c1), 32'd7);
        chk("indep_count2", 32'(c2), 32'd5);

        // Asynchronous reset with both slots held
        r1 = 1'b0;
        r2 = 1'b0;
        send(8'h81, 1'b0, w);
        send(8'h82, 1'b1, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid1", 32'(v1), 32'd0);
        chk("midrst_valid2", 32'(v2), 32'd0);
        chk("midrst_count1", 32'(c1), 32'd0);
        chk("midrst_count2", 32'(c2), 32'd0);
        chk("midrst_data2", 32'(d2), 32'd0);
        chk("midrst_ready", 32'(rdyOut), 32'd0);
        q1.delete();
        q2.delete();
        m1      = 4'd0;
        m2      = 4'd0;
        rrModel = 1'b0;
        r1      = 1'b1;
        r2      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", 32'(rdyOut), 32'd1);
        @(posedge clk);
        #1;

        // Counter wrap on channel 2
        for (int i = 0; i < 17; i++) begin
            send(8'hC0 + 8'(i), 1'b1, w);
        end
        waitEmpty();
        chk("wrap_count2", 32'(c2), 32'd1);
        chk("wrap_count1", 32'(c1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
